// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, keeps one request in flight and buffers one
// instruction for decode. Optional macro FETCH_PERF_CNT_EN adds a fetch handshake counter.
module fetch_stage #(
  parameter int               XLEN      = 32,
  parameter logic [XLEN-1:0]  RESET_PC  = '0,
  parameter logic [XLEN-1:0]  NOP_INSTR = XLEN'(32'h0000_0013)
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [XLEN-1:0] id_instr,
  output logic [XLEN-1:0] id_pc,
  output logic [6:0]      id_opcode
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]     perf_fetch_cnt
`endif
);

  typedef enum logic {S_REQ, S_WAIT} state_t;

  state_t          state, state_next;
  logic [XLEN-1:0] pc, pc_next;
  logic [XLEN-1:0] req_pc, req_pc_next;
  logic            drop, drop_next;
  logic            load;
  logic            id_fire;
  logic            unused_redirect_bits;

  assign id_fire              = id_valid && id_ready;
  assign imem_addr            = pc;
  assign id_opcode            = id_instr[6:0];
  assign unused_redirect_bits = ^redirect_pc[1:0];

  // NOTE: every signal written here gets a default first, so no path leaves a latch behind.
  always_comb begin
    state_next     = state;
    pc_next        = pc;
    req_pc_next    = req_pc;
    drop_next      = drop;
    load           = 1'b0;
    imem_req_valid = 1'b0;
    case (state)
      S_REQ: begin
        // rst_n gates the request so memory never sees a request while reset is held.
        imem_req_valid = rst_n && (!id_valid || id_ready) && !redirect_valid;
        if (imem_req_valid && imem_req_ready) begin
          req_pc_next = pc;
          pc_next     = pc + XLEN'(4);
          state_next  = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_rsp_valid) begin
          load       = !drop && !redirect_valid;
          drop_next  = 1'b0;
          state_next = S_REQ;
        end else if (redirect_valid) begin
          drop_next = 1'b1;
        end
      end
      default: state_next = S_REQ;
    endcase
    if (redirect_valid) pc_next = {redirect_pc[XLEN-1:2], 2'b00};
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_REQ;
      pc     <= RESET_PC;
      req_pc <= '0;
      drop   <= 1'b0;
    end else begin
      state  <= state_next;
      pc     <= pc_next;
      req_pc <= req_pc_next;
      drop   <= drop_next;
    end
  end

  // Flush beats a fresh load, which beats a plain drain of the buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_valid <= 1'b0;
      id_instr <= NOP_INSTR;
      id_pc    <= '0;
    end else if (redirect_valid) begin
      id_valid <= 1'b0;
      id_instr <= NOP_INSTR;
    end else if (load) begin
      id_valid <= 1'b1;
      id_instr <= imem_rsp_data;
      id_pc    <= req_pc;
    end else if (id_fire) begin
      id_valid <= 1'b0;
      id_instr <= NOP_INSTR;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       perf_fetch_cnt <= '0;
    else if (id_fire) perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a reactive memory model with programmable latency drives
// the main instance; a second instance with RESET_PC=0xFFFF_FFFC covers PC wrap.
module tb_fetch_stage;

  logic        clk;
  logic        rst_n;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid, id_ready;
  logic [31:0] id_instr, id_pc;
  logic [6:0]  id_opcode;

  logic        w_req_valid;
  logic [31:0] w_addr;
  logic        w_rsp_valid;
  logic [31:0] w_rsp_data;
  logic        w_id_valid;
  logic [31:0] w_id_instr, w_id_pc;
  logic [6:0]  w_id_opcode;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt, w_perf_fetch_cnt;
`endif

  int          n_checks = 0;
  int          n_fail   = 0;
  int          mem_lat  = 1;
  int          mem_cnt  = 0;
  logic [31:0] mem_q    = '0;
  logic [31:0] mem_xor  = '0;
  logic        w_pend   = 1'b0;
  logic [31:0] w_q      = '0;

  fetch_stage u_dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .id_valid(id_valid), .id_ready(id_ready), .id_instr(id_instr), .id_pc(id_pc),
    .id_opcode(id_opcode)
`ifdef FETCH_PERF_CNT_EN
    , .perf_fetch_cnt(perf_fetch_cnt)
`endif
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(w_req_valid), .imem_req_ready(1'b1), .imem_addr(w_addr),
    .imem_rsp_valid(w_rsp_valid), .imem_rsp_data(w_rsp_data),
    .redirect_valid(1'b0), .redirect_pc(32'h0),
    .id_valid(w_id_valid), .id_ready(1'b1), .id_instr(w_id_instr), .id_pc(w_id_pc),
    .id_opcode(w_id_opcode)
`ifdef FETCH_PERF_CNT_EN
    , .perf_fetch_cnt(w_perf_fetch_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory acts at the falling edge: a request seen here is accepted at the next rising edge,
  // and the response is raised mem_lat falling edges later for exactly one cycle.
  always @(negedge clk) begin
    if (mem_cnt != 0) begin
      mem_cnt        = mem_cnt - 1;
      imem_rsp_valid = (mem_cnt == 0);
    end else begin
      imem_rsp_valid = 1'b0;
    end
    imem_rsp_data = imem_rsp_valid ? (mem_q ^ mem_xor) : 32'h0;
    if (imem_req_valid && imem_req_ready) begin
      mem_cnt = mem_lat;
      mem_q   = imem_addr;
    end
  end

  always @(negedge clk) begin
    w_rsp_valid = w_pend;
    w_rsp_data  = w_q;
    w_pend      = w_req_valid;
    if (w_req_valid) w_q = w_addr;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp)
      else begin
        n_fail++;
        $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!id_valid && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_valid"}, 32'(id_valid), 32'h1);
  endtask

  initial begin
    rst_n          = 1'b0;
    imem_req_ready = 1'b1;
    id_ready       = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    w_rsp_valid    = 1'b0;
    w_rsp_data     = '0;

    repeat (2) tick();
    check("rst_id_valid", 32'(id_valid), 32'h0);
    check("rst_id_instr", id_instr, 32'h0000_0013);
    check("rst_id_pc", id_pc, 32'h0);
    check("rst_req_valid", 32'(imem_req_valid), 32'h0);
    check("rst_addr", imem_addr, 32'h0);
    check("rst_wrap_addr", w_addr, 32'hFFFF_FFFC);

    // Streaming: handshake at edge 1, first instruction visible after edge 2, then every 2nd cycle.
    rst_n = 1'b1;
    tick();
    check("e1_id_valid", 32'(id_valid), 32'h0);
    check("e1_req_valid", 32'(imem_req_valid), 32'h0);
    tick();
    check("e2_id_valid", 32'(id_valid), 32'h1);
    check("e2_id_pc", id_pc, 32'h0);
    check("e2_id_instr", id_instr, 32'h0);
    check("e2_req_valid", 32'(imem_req_valid), 32'h1);
    check("e2_addr", imem_addr, 32'h4);
    check("wrap_pc0", w_id_pc, 32'hFFFF_FFFC);
    tick();
    check("e3_id_valid", 32'(id_valid), 32'h0);
    tick();
    check("e4_id_valid", 32'(id_valid), 32'h1);
    check("e4_id_pc", id_pc, 32'h4);
    check("e4_opcode", 32'(id_opcode), 32'h4);
    check("wrap_valid1", 32'(w_id_valid), 32'h1);
    check("wrap_pc1", w_id_pc, 32'h0);

    // Backpressure: buffer and its PC hold, and no request leaves.
    id_ready = 1'b0;
    #1;
    check("bp_req_now", 32'(imem_req_valid), 32'h0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_id_valid", 32'(id_valid), 32'h1);
      check("bp_id_pc", id_pc, 32'h4);
      check("bp_id_instr", id_instr, 32'h4);
      check("bp_req_valid", 32'(imem_req_valid), 32'h0);
    end
    id_ready = 1'b1;
    #1;
    check("bp_rel_req", 32'(imem_req_valid), 32'h1);
    check("bp_rel_addr", imem_addr, 32'h8);
    tick();
    check("bp_consumed", 32'(id_valid), 32'h0);
    tick();
    check("pc8_id_pc", id_pc, 32'h8);

    // Redirect during a 3-cycle wait: the stale response is dropped.
    mem_lat = 3;
    mem_xor = 32'h1234_5067;
    tick();
    check("rd_wait_valid", 32'(id_valid), 32'h0);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    tick();
    redirect_valid = 1'b0;
    #1;
    check("rd_addr_wait", imem_addr, 32'h100);
    check("rd_req_wait", 32'(imem_req_valid), 32'h0);
    tick();
    check("rd_drop1", 32'(id_valid), 32'h0);
    tick();
    check("rd_drop2", 32'(id_valid), 32'h0);
    check("rd_req_after", 32'(imem_req_valid), 32'h1);
    check("rd_addr_after", imem_addr, 32'h100);
    wait_valid("rd_tgt");
    check("rd_tgt_pc", id_pc, 32'h100);
    check("rd_tgt_instr", id_instr, 32'h1234_5167);
    check("rd_tgt_opcode", 32'(id_opcode), 32'h67);

    // Misaligned target, also coinciding with a decode handshake.
    redirect_valid = 1'b1;
    redirect_pc    = 32'h103;
    #1;
    check("mis_req_blocked", 32'(imem_req_valid), 32'h0);
    tick();
    redirect_valid = 1'b0;
    mem_lat        = 1;
    #1;
    check("mis_flush", 32'(id_valid), 32'h0);
    check("mis_flush_instr", id_instr, 32'h0000_0013);
    check("mis_addr", imem_addr, 32'h100);
    check("mis_req", 32'(imem_req_valid), 32'h1);
    wait_valid("mis_tgt");
    check("mis_tgt_pc", id_pc, 32'h100);

    // Redirect in the same cycle as the response.
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h200;
    tick();
    redirect_valid = 1'b0;
    #1;
    check("same_no_valid", 32'(id_valid), 32'h0);
    check("same_req", 32'(imem_req_valid), 32'h1);
    check("same_addr", imem_addr, 32'h200);
    tick();
    check("same_still_empty", 32'(id_valid), 32'h0);
    tick();
    check("same_tgt_valid", 32'(id_valid), 32'h1);
    check("same_tgt_pc", id_pc, 32'h200);
    check("same_tgt_instr", id_instr, 32'h1234_5267);

    // Back-to-back redirects: the last target wins.
    redirect_valid = 1'b1;
    redirect_pc    = 32'h300;
    tick();
    redirect_pc = 32'h400;
    tick();
    redirect_valid = 1'b0;
    #1;
    check("b2b_addr", imem_addr, 32'h400);
    check("b2b_flush", 32'(id_valid), 32'h0);

    // Reset during WAIT; the late response lands in REQ and is ignored.
    mem_lat = 3;
    tick();
    check("rw_in_wait", 32'(imem_req_valid), 32'h0);
    rst_n          = 1'b0;
    imem_req_ready = 1'b0;
    #1;
    check("rw_id_valid", 32'(id_valid), 32'h0);
    check("rw_id_pc", id_pc, 32'h0);
    check("rw_addr", imem_addr, 32'h0);
    check("rw_req", 32'(imem_req_valid), 32'h0);
    tick();
    rst_n = 1'b1;
    #1;
    check("rw_req_held", 32'(imem_req_valid), 32'h1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rw_stale_ignored", 32'(id_valid), 32'h0);
      check("rw_addr_held", imem_addr, 32'h0);
    end
    imem_req_ready = 1'b1;
    mem_lat        = 1;
    wait_valid("rw_first");
    check("rw_first_pc", id_pc, 32'h0);
    check("rw_first_instr", id_instr, 32'h1234_5067);

    // Ten consumed instructions with a backpressure gap in the middle.
    rst_n = 1'b0;
    #1;
`ifdef FETCH_PERF_CNT_EN
    check("perf_rst", perf_fetch_cnt, 32'h0);
`endif
    tick();
    rst_n   = 1'b1;
    mem_xor = '0;
    for (int i = 0; i < 10; i++) begin
      wait_valid("run");
      check("run_pc", id_pc, 32'(4 * i));
      if (i == 5) begin
        id_ready = 1'b0;
        repeat (3) tick();
        check("run_bp_pc", id_pc, 32'h14);
`ifdef FETCH_PERF_CNT_EN
        check("perf_bp", perf_fetch_cnt, 32'd5);
`endif
        id_ready = 1'b1;
      end
      tick();
    end
`ifdef FETCH_PERF_CNT_EN
    check("perf_10", perf_fetch_cnt, 32'd10);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
